// File: rtl/alu_interface.sv
// ============================================================================
// alu_interface
// ----------------------------------------------------------------------------
// Connects a byte-wide UART to a combinational ALU. Every frame is made of
// operand A, then operand B, then one opcode byte. Each operand arrives as
// DATA_WIDTH/8 bytes, least significant byte first. Once the opcode arrives
// the ALU result is captured and sent back through the transmitter, least
// significant byte first, one byte per transmit handshake.
//
// Parameters
//   DATA_WIDTH     ALU operand/result width (8 or 16)
//   OP_WIDTH       ALU opcode width
//   TIMEOUT_CYCLES inter-byte timeout in clocks (used only with the macro)
//
// Ports
//   i_clk       clock, all logic on the rising edge
//   i_rst_n     asynchronous active-low reset
//   i_rx_data   byte from the UART receiver
//   i_rx_done   one-cycle strobe, i_rx_data is valid
//   i_tx_done   one-cycle strobe, the transmitter finished a byte
//   i_resultado combinational ALU result
//   o_dato_A    ALU operand A
//   o_dato_B    ALU operand B
//   o_op        ALU opcode
//   o_tx_data   byte handed to the UART transmitter
//   o_tx_start  one-cycle transmit request
//   o_error     one-cycle pulse on a dropped byte or an inter-byte timeout
//
// Build option
//   ALU_IF_TIMEOUT_EN  when defined, a partially received frame is abandoned
//                      after TIMEOUT_CYCLES idle clocks. When undefined the
//                      block waits forever for each byte.
// ============================================================================
module alu_interface #(
   parameter int DATA_WIDTH     = 8,
   parameter int OP_WIDTH       = 6,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [7:0]            i_rx_data,
   input  logic                  i_rx_done,
   input  logic                  i_tx_done,
   input  logic [DATA_WIDTH-1:0] i_resultado,
   output logic [DATA_WIDTH-1:0] o_dato_A,
   output logic [DATA_WIDTH-1:0] o_dato_B,
   output logic [OP_WIDTH-1:0]   o_op,
   output logic [7:0]            o_tx_data,
   output logic                  o_tx_start,
   output logic                  o_error
);

   localparam int NB = DATA_WIDTH / 8;
   localparam logic [1:0] LAST_BYTE = 2'(NB - 1);

   typedef enum logic [2:0] {
      RX_A,
      RX_B,
      RX_OP,
      EXEC,
      TX_START,
      TX_WAIT
   } stateT;

   stateT state;
   stateT nextState;

   logic [1:0]            byteCnt;
   logic [1:0]            nextByteCnt;
   logic [DATA_WIDTH-1:0] resultReg;

   logic loadA;
   logic loadB;
   logic loadOp;
   logic captureResult;
   logic launchTx;
   logic dropByte;
   logic timeoutHit;

`ifdef ALU_IF_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] timeoutCnt;
   logic            frameActive;

   // A frame is "in progress" once its first byte has landed and until the
   // opcode byte arrives; only then is there something worth abandoning.
   always_comb begin
      frameActive = 1'b0;
      if ((state == RX_A) && (byteCnt != 2'd0)) begin
         frameActive = 1'b1;
      end else if ((state == RX_B) || (state == RX_OP)) begin
         frameActive = 1'b1;
      end
   end

   // The timeout fires on the edge where the counter would reach
   // TIMEOUT_CYCLES. A byte arriving in that same cycle wins, because it
   // restarts the idle time.
   always_comb begin
      timeoutHit = 1'b0;
      if (frameActive && !i_rx_done &&
          (timeoutCnt == TO_W'(TIMEOUT_CYCLES - 1))) begin
         timeoutHit = 1'b1;
      end
   end

   // Idle-clock counter: restarts on every received byte and whenever no
   // frame is in progress, so only the gap since the last byte counts.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         timeoutCnt <= '0;
      end else if (i_rx_done || !frameActive || timeoutHit) begin
         timeoutCnt <= '0;
      end else begin
         timeoutCnt <= timeoutCnt + 1'b1;
      end
   end
`else
   logic unusedTimeoutParam;

   // Without the timeout option the receiver simply waits for each byte.
   assign timeoutHit         = 1'b0;
   assign unusedTimeoutParam = (TIMEOUT_CYCLES > 0);
`endif

   // State and byte-counter register. The byte counter is shared: it walks
   // through operand bytes while receiving and result bytes while sending.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= RX_A;
         byteCnt <= 2'd0;
      end else begin
         state   <= nextState;
         byteCnt <= nextByteCnt;
      end
   end

   // Next-state logic plus the one-cycle strobes that drive the datapath
   // registers. Bytes arriving while the result is being computed or sent
   // are flagged as dropped instead of being absorbed.
   always_comb begin
      nextState     = state;
      nextByteCnt   = byteCnt;
      loadA         = 1'b0;
      loadB         = 1'b0;
      loadOp        = 1'b0;
      captureResult = 1'b0;
      launchTx      = 1'b0;
      dropByte      = 1'b0;

      case (state)
         RX_A: begin
            if (timeoutHit) begin
               nextState   = RX_A;
               nextByteCnt = 2'd0;
            end else if (i_rx_done) begin
               loadA = 1'b1;
               if (byteCnt == LAST_BYTE) begin
                  nextState   = RX_B;
                  nextByteCnt = 2'd0;
               end else begin
                  nextByteCnt = byteCnt + 2'd1;
               end
            end
         end

         RX_B: begin
            if (timeoutHit) begin
               nextState   = RX_A;
               nextByteCnt = 2'd0;
            end else if (i_rx_done) begin
               loadB = 1'b1;
               if (byteCnt == LAST_BYTE) begin
                  nextState   = RX_OP;
                  nextByteCnt = 2'd0;
               end else begin
                  nextByteCnt = byteCnt + 2'd1;
               end
            end
         end

         RX_OP: begin
            if (timeoutHit) begin
               nextState   = RX_A;
               nextByteCnt = 2'd0;
            end else if (i_rx_done) begin
               loadOp    = 1'b1;
               nextState = EXEC;
            end
         end

         EXEC: begin
            captureResult = 1'b1;
            dropByte      = i_rx_done;
            nextState     = TX_START;
            nextByteCnt   = 2'd0;
         end

         TX_START: begin
            launchTx  = 1'b1;
            dropByte  = i_rx_done;
            nextState = TX_WAIT;
         end

         TX_WAIT: begin
            dropByte = i_rx_done;
            if (i_tx_done) begin
               if (byteCnt == LAST_BYTE) begin
                  nextState   = RX_A;
                  nextByteCnt = 2'd0;
               end else begin
                  nextState   = TX_START;
                  nextByteCnt = byteCnt + 2'd1;
               end
            end
         end

         default: begin
            nextState   = RX_A;
            nextByteCnt = 2'd0;
         end
      endcase
   end

   // Operand and opcode registers. They only change on a load, so the ALU
   // keeps seeing the previous frame until a new byte overwrites it, and a
   // timed-out partial frame leaves whatever bytes it already wrote.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_dato_A <= '0;
         o_dato_B <= '0;
         o_op     <= '0;
      end else begin
         if (loadA) begin
            o_dato_A[{byteCnt, 3'b000} +: 8] <= i_rx_data;
         end
         if (loadB) begin
            o_dato_B[{byteCnt, 3'b000} +: 8] <= i_rx_data;
         end
         if (loadOp) begin
            o_op <= i_rx_data[OP_WIDTH-1:0];
         end
      end
   end

   // The ALU result is snapshotted in EXEC so the transmitted bytes stay
   // consistent even if the operands were to change during transmission.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         resultReg <= '0;
      end else if (captureResult) begin
         resultReg <= i_resultado;
      end
   end

   // Transmit side. The byte and its start pulse are registered together on
   // the TX_START edge; the byte then holds until the next TX_START, which
   // keeps it stable for the whole handshake.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_tx_data  <= 8'd0;
         o_tx_start <= 1'b0;
      end else begin
         o_tx_start <= launchTx;
         if (launchTx) begin
            o_tx_data <= resultReg[{byteCnt, 3'b000} +: 8];
         end
      end
   end

   // Error pulse, registered so it appears one cycle after the dropped byte
   // strobe or the timeout edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_error <= 1'b0;
      end else begin
         o_error <= dropByte | timeoutHit;
      end
   end

endmodule

// File: tb/tb_alu_interface.sv
// ============================================================================
// tb_alu_interface
// ----------------------------------------------------------------------------
// Directed bench for alu_interface. Two instances share clock and reset: an
// 8-bit one (inter-byte timeout of 50 clocks) and a 16-bit one. Each has a
// tiny behavioural ALU so the transmitted result depends on the operands and
// opcode the interface actually presents. Expected values are hand-computed.
// ============================================================================
module tb_alu_interface;

   logic        clk;
   logic        rstN;

   logic [7:0]  rxData8;
   logic        rxDone8;
   logic        txDone8;
   logic [7:0]  res8;
   logic [7:0]  a8;
   logic [7:0]  b8;
   logic [5:0]  op8;
   logic [7:0]  txData8;
   logic        txStart8;
   logic        err8;

   logic [7:0]  rxData16;
   logic        rxDone16;
   logic        txDone16;
   logic [15:0] res16;
   logic [15:0] a16;
   logic [15:0] b16;
   logic [5:0]  op16;
   logic [7:0]  txData16;
   logic        txStart16;
   logic        err16;

   int compared;
   int mismatched;
   int cycles;

   alu_interface #(
      .DATA_WIDTH    (8),
      .OP_WIDTH      (6),
      .TIMEOUT_CYCLES(50)
   ) dut8 (
      .i_clk      (clk),
      .i_rst_n    (rstN),
      .i_rx_data  (rxData8),
      .i_rx_done  (rxDone8),
      .i_tx_done  (txDone8),
      .i_resultado(res8),
      .o_dato_A   (a8),
      .o_dato_B   (b8),
      .o_op       (op8),
      .o_tx_data  (txData8),
      .o_tx_start (txStart8),
      .o_error    (err8)
   );

   alu_interface #(
      .DATA_WIDTH(16),
      .OP_WIDTH  (6)
   ) dut16 (
      .i_clk      (clk),
      .i_rst_n    (rstN),
      .i_rx_data  (rxData16),
      .i_rx_done  (rxDone16),
      .i_tx_done  (txDone16),
      .i_resultado(res16),
      .o_dato_A   (a16),
      .o_dato_B   (b16),
      .o_op       (op16),
      .o_tx_data  (txData16),
      .o_tx_start (txStart16),
      .o_error    (err16)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural ALUs: ADD 0x20, SUB 0x22, AND 0x24, SRA 0x03.
   always_comb begin
      res8 = 8'h00;
      case (op8)
         6'h20:   res8 = a8 + b8;
         6'h22:   res8 = a8 - b8;
         6'h24:   res8 = a8 & b8;
         6'h03:   res8 = $signed(a8) >>> b8;
         default: res8 = 8'h00;
      endcase
   end

   always_comb begin
      res16 = 16'h0000;
      case (op16)
         6'h20:   res16 = a16 + b16;
         6'h22:   res16 = a16 - b16;
         6'h24:   res16 = a16 & b16;
         6'h03:   res16 = $signed(a16) >>> b16;
         default: res16 = 16'h0000;
      endcase
   end

   // One receive strobe, driven on a falling edge and held for one cycle.
   task automatic applyStimulus(input bit wide, input logic [7:0] value);
      @(negedge clk);
      if (wide) begin
         rxData16 = value;
         rxDone16 = 1'b1;
      end else begin
         rxData8 = value;
         rxDone8 = 1'b1;
      end
      @(negedge clk);
      rxDone8  = 1'b0;
      rxDone16 = 1'b0;
   endtask

   // One transmit-done strobe.
   task automatic pulseTxDone(input bit wide);
      @(negedge clk);
      if (wide) txDone16 = 1'b1;
      else      txDone8  = 1'b1;
      @(negedge clk);
      txDone8  = 1'b0;
      txDone16 = 1'b0;
   endtask

   // Waits (bounded) for o_tx_start; the count starts at 1 on the falling
   // edge right after a receive strobe, so it counts edges since the strobe.
   task automatic waitTxStart(input bit wide, output int n);
      n = 1;
      while (((wide ? txStart16 : txStart8) == 1'b0) && (n < 60)) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rstN       = 1'b0;
      rxData8    = 8'h00;
      rxDone8    = 1'b0;
      txDone8    = 1'b0;
      rxData16   = 8'h00;
      rxDone16   = 1'b0;
      txDone16   = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      checkOutput("rstA8",     32'(a8), 32'h00);
      checkOutput("rstTxStart8", 32'(txStart8), 32'h0);
      checkOutput("rstErr8",   32'(err8), 32'h0);
      checkOutput("rstA16",    32'(a16), 32'h0000);
      checkOutput("rstTxData16", 32'(txData16), 32'h00);
      rstN = 1'b1;
      repeat (2) @(negedge clk);

      // ADD: 0x10 + 0x02 = 0x12, tx start 3 edges after the op strobe
      applyStimulus(1'b0, 8'h10);
      applyStimulus(1'b0, 8'h02);
      applyStimulus(1'b0, 8'h20);
      waitTxStart(1'b0, cycles);
      checkOutput("addLatency", 32'(cycles), 32'd3);
      checkOutput("addTxData",  32'(txData8), 32'h12);
      @(negedge clk);
      checkOutput("addStartOneCycle", 32'(txStart8), 32'h0);
      pulseTxDone(1'b0);

      // A stray tx done while idle must be ignored
      pulseTxDone(1'b0);

      // SRA: 0x90 >>> 2 = 0xE4
      applyStimulus(1'b0, 8'h90);
      applyStimulus(1'b0, 8'h02);
      applyStimulus(1'b0, 8'h03);
      checkOutput("sraA",  32'(a8), 32'h90);
      checkOutput("sraB",  32'(b8), 32'h02);
      checkOutput("sraOp", 32'(op8), 32'h03);
      waitTxStart(1'b0, cycles);
      checkOutput("sraStart",  32'(txStart8), 32'h1);
      checkOutput("sraTxData", 32'(txData8), 32'hE4);
      pulseTxDone(1'b0);

      // 16-bit SUB: 0x0010 - 0x0002 = 0x000E, sent as 0x0E then 0x00
      applyStimulus(1'b1, 8'h10);
      applyStimulus(1'b1, 8'h00);
      applyStimulus(1'b1, 8'h02);
      applyStimulus(1'b1, 8'h00);
      applyStimulus(1'b1, 8'h22);
      checkOutput("subA16",  32'(a16), 32'h0010);
      checkOutput("subB16",  32'(b16), 32'h0002);
      checkOutput("subOp16", 32'(op16), 32'h22);
      waitTxStart(1'b1, cycles);
      checkOutput("subLatency16", 32'(cycles), 32'd3);
      checkOutput("subByte0", 32'(txData16), 32'h0E);
      @(negedge clk);
      checkOutput("subHoldData", 32'(txData16), 32'h0E);
      checkOutput("subNoEarlyStart", 32'(txStart16), 32'h0);
      pulseTxDone(1'b1);
      waitTxStart(1'b1, cycles);
      checkOutput("subStart1", 32'(txStart16), 32'h1);
      checkOutput("subByte1",  32'(txData16), 32'h00);
      pulseTxDone(1'b1);
      repeat (2) @(negedge clk);
      checkOutput("subNoThirdByte", 32'(txStart16), 32'h0);

      // Byte dropped during TX_WAIT: one error pulse, frame unchanged
      applyStimulus(1'b0, 8'h07);
      applyStimulus(1'b0, 8'h08);
      applyStimulus(1'b0, 8'h20);
      waitTxStart(1'b0, cycles);
      checkOutput("dropStart", 32'(txStart8), 32'h1);
      applyStimulus(1'b0, 8'hAA);
      checkOutput("dropErrPulse", 32'(err8), 32'h1);
      @(negedge clk);
      checkOutput("dropErrOneCycle", 32'(err8), 32'h0);
      checkOutput("dropTxData", 32'(txData8), 32'h0F);
      checkOutput("dropAKept",  32'(a8), 32'h07);
      pulseTxDone(1'b0);

      // Next frame decodes normally; op byte 0xE0 keeps only the low 6 bits
      applyStimulus(1'b0, 8'h01);
      applyStimulus(1'b0, 8'h02);
      applyStimulus(1'b0, 8'hE0);
      checkOutput("nextOp", 32'(op8), 32'h20);
      waitTxStart(1'b0, cycles);
      checkOutput("nextLatency", 32'(cycles), 32'd3);
      checkOutput("nextTxData",  32'(txData8), 32'h03);
      pulseTxDone(1'b0);

      // Reset after A and B: everything clears immediately
      applyStimulus(1'b0, 8'h11);
      applyStimulus(1'b0, 8'h22);
      @(negedge clk);
      rstN = 1'b0;
      #1;
      checkOutput("midRstA",   32'(a8), 32'h00);
      checkOutput("midRstB",   32'(b8), 32'h00);
      checkOutput("midRstOp",  32'(op8), 32'h00);
      checkOutput("midRstTxData", 32'(txData8), 32'h00);
      checkOutput("midRstTxStart", 32'(txStart8), 32'h0);
      checkOutput("midRstErr", 32'(err8), 32'h0);
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);

      // AND after reset: 0x05 & 0x03 = 0x01
      applyStimulus(1'b0, 8'h05);
      applyStimulus(1'b0, 8'h03);
      applyStimulus(1'b0, 8'h24);
      checkOutput("andA", 32'(a8), 32'h05);
      checkOutput("andB", 32'(b8), 32'h03);
      waitTxStart(1'b0, cycles);
      checkOutput("andStart",  32'(txStart8), 32'h1);
      checkOutput("andTxData", 32'(txData8), 32'h01);
      pulseTxDone(1'b0);

`ifdef ALU_IF_TIMEOUT_EN
      // Timeout: one byte then silence; error 51 edges after the strobe
      applyStimulus(1'b0, 8'h33);
      checkOutput("toFirstA", 32'(a8), 32'h33);
      cycles = 1;
      while ((err8 == 1'b0) && (cycles < 80)) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("toErrSeen",  32'(err8), 32'h1);
      checkOutput("toErrDelay", 32'(cycles), 32'd51);
      @(negedge clk);
      checkOutput("toErrOneCycle", 32'(err8), 32'h0);
      checkOutput("toBKept", 32'(b8), 32'h03);
      applyStimulus(1'b0, 8'h44);
      checkOutput("toNextA", 32'(a8), 32'h44);
      checkOutput("toNextBKept", 32'(b8), 32'h03);
`endif

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/alu_interface.md
ALU_INTERFACE -- requirements
Module: alu_interface

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the ALU operand/result width; legal values are 8 and 16.
REQ-002 The block SHALL have parameter OP_WIDTH, default 6, the ALU opcode width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 100000, the inter-byte timeout in clocks.
REQ-004 The block SHALL have port i_clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port i_rst_n, input, 1, the asynchronous active-low reset.
REQ-006 The block SHALL have port i_rx_data, input, 8, the byte from the UART receiver.
REQ-007 The block SHALL have port i_rx_done, input, 1, a one-cycle strobe meaning i_rx_data is valid.
REQ-008 The block SHALL have port i_tx_done, input, 1, a one-cycle strobe from the UART transmitter meaning the byte was sent.
REQ-009 The block SHALL have port i_resultado, input, DATA_WIDTH, the combinational ALU result.
REQ-010 The block SHALL have port o_dato_A, output, DATA_WIDTH, ALU operand A.
REQ-011 The block SHALL have port o_dato_B, output, DATA_WIDTH, ALU operand B.
REQ-012 The block SHALL have port o_op, output, OP_WIDTH, the ALU opcode.
REQ-013 The block SHALL have port o_tx_data, output, 8, the byte sent to the UART transmitter.
REQ-014 The block SHALL have port o_tx_start, output, 1, a one-cycle transmit request.
REQ-015 The block SHALL have port o_error, output, 1, a one-cycle pulse on a dropped byte or timeout.

Function
REQ-016 The FSM SHALL have states RX_A, RX_B, RX_OP, EXEC, TX_START and TX_WAIT; with NB = DATA_WIDTH/8, each operand takes NB bytes, least significant byte first.
REQ-017 In RX_A, each i_rx_done SHALL load i_rx_data into the next byte of o_dato_A; after the NB-th byte the FSM goes to RX_B.
REQ-018 RX_B SHALL behave the same way for o_dato_B, then go to RX_OP.
REQ-019 In RX_OP, i_rx_done SHALL load i_rx_data[OP_WIDTH-1:0] into o_op, ignore the upper bits, and go to EXEC.
REQ-020 EXEC SHALL last exactly one cycle, capture i_resultado into an internal result register, and go to TX_START.
REQ-021 TX_START SHALL drive o_tx_data with result byte k (LSB first), assert o_tx_start for exactly one cycle, and go to TX_WAIT.
REQ-022 In TX_WAIT, on i_tx_done the FSM SHALL go to TX_START if bytes remain, otherwise to RX_A with the byte counter cleared.
REQ-023 o_dato_A, o_dato_B and o_op SHALL hold their values until overwritten by a new load.
REQ-024 An i_rx_done arriving in EXEC, TX_START or TX_WAIT SHALL be discarded without affecting state, and SHALL pulse o_error one cycle later.
REQ-025 An i_tx_done arriving outside TX_WAIT SHALL be ignored.
REQ-026 Latency from the i_rx_done of the opcode byte to the first o_tx_start SHALL be 3 cycles: op load, EXEC, TX_START.
REQ-027 o_tx_data SHALL remain stable from TX_START until i_tx_done.

Reset
REQ-028 While i_rst_n = 0, the block SHALL immediately force the FSM to RX_A, the byte counter to 0, o_dato_A, o_dato_B, o_op, o_tx_data and the result register to 0, and o_tx_start and o_error to 0.
REQ-029 A reset asserted mid-frame or mid-transmission SHALL abandon the frame; after reset release, the next received byte is treated as byte 0 of A.

Configuration
REQ-030 With macro ALU_IF_TIMEOUT_EN defined, a counter SHALL run in RX_A, RX_B and RX_OP whenever at least one byte of the current frame has been received; the counter clears on each i_rx_done.
REQ-031 With ALU_IF_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the block SHALL return to RX_A with the byte counter at 0, keep the operand registers unchanged, and pulse o_error.
REQ-032 With ALU_IF_TIMEOUT_EN undefined, no counter SHALL exist and the block SHALL wait indefinitely for each byte.

Verification
REQ-033 The bench SHALL cover: DATA_WIDTH=8, rx 0x10, 0x02, 0x20 (ADD), ALU returns 0x12 -> one o_tx_start with o_tx_data=0x12, 3 cycles after the op strobe.
REQ-034 The bench SHALL cover: DATA_WIDTH=8, rx 0x90, 0x02, 0x03 (SRA) -> o_dato_A=0x90, o_dato_B=0x02, o_op=0x03, transmitted byte 0xE4.
REQ-035 The bench SHALL cover: DATA_WIDTH=16, rx 0x10, 0x00, 0x02, 0x00, 0x22 (SUB) -> o_dato_A=0x0010, o_dato_B=0x0002, o_op=0x22, then bytes 0x0E and 0x00, each following i_tx_done.
REQ-036 The bench SHALL cover: an i_rx_done pulse during TX_WAIT -> one o_error pulse, unchanged frame transmitted, and the next frame decoded correctly.
REQ-037 The bench SHALL cover: i_rst_n low after the A and B bytes are received -> all outputs 0; the next rx 0x05, 0x03, 0x24 (AND) transmits the ALU result of 0x05 & 0x03 = 0x01.
REQ-038 The bench SHALL cover: with ALU_IF_TIMEOUT_EN defined and TIMEOUT_CYCLES=50, rx one byte then idle for 50 cycles -> o_error pulse, state RX_A, and the following byte loads o_dato_A.
